multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing a multicycle MIPS-style datapath.
// Ports:
//   clk, reset_n            - clock, synchronous active-low reset
//   instr                   - instruction register contents (valid from DECODE)
//   alu_zero, alu_overflow  - ALU status for the current cycle
//   mem_ready               - memory completes the current request this cycle
//   ir_we, pc_we, reg_we    - IR / PC / register-file write enables
//   mem_req, mem_we         - memory request and write strobe
//   pc_src                  - 0=PC+4, 1=branch target, 2=jump target, 3=rs
//   mem_addr_sel            - 0=PC, 1=ALU result
//   alu_src_b               - 0=rt, 1=sign-extended imm, 2=zero-extended imm
//   reg_dst, wb_sel         - 0=rt/1=rd/2=r31 ; 0=ALU/1=mem data/2=PC
//   alu_opcode, alu_funct   - instruction fields latched in DECODE
//   state, illegal          - current state encoding, sticky illegal flag
module multicycle_controller #(
   parameter bit OVF_SUPPRESS = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instr,
   input  logic        alu_zero,
   input  logic        alu_overflow,
   input  logic        mem_ready,
   output logic        ir_we,
   output logic        pc_we,
   output logic        reg_we,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  pc_src,
   output logic        mem_addr_sel,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wb_sel,
   output logic [5:0]  alu_opcode,
   output logic [5:0]  alu_funct,
   output logic [3:0]  state,
   output logic        illegal
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, ALU_WB = 4'd3,
      EXEC_I = 4'd4, MEM_ADDR = 4'd5, MEM_RD = 4'd6, MEM_WB = 4'd7,
      MEM_WR = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, JR = 4'd11, HALT = 4'd12
   } state_t;

   state_t     curState, nextState, decodeNext;
   logic [5:0] opReg, functReg;
   logic       illegalReg;
   logic       irWe, pcWe, regWe, memReq, memWe;
   logic       isRType, ovfOp;

   assign isRType = opReg == 6'b000000;
   // Only signed-arithmetic ops trap on overflow; SLT and XORI always write back.
   assign ovfOp   = (isRType && (functReg == 6'b100000 || functReg == 6'b100010)) || opReg == 6'b001000;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         curState   <= FETCH;
         illegalReg <= 1'b0;
         opReg      <= 6'b000000;
         functReg   <= 6'b100000;
      end else begin
         curState <= nextState;
         if (curState == DECODE) begin
            opReg    <= instr[31:26];
            functReg <= instr[5:0];
         end
         if (nextState == HALT) illegalReg <= 1'b1;
      end
   end

   // Dispatch looks at the live instruction since the latched fields update on the DECODE edge.
   always_comb begin
      decodeNext = HALT;
      case (instr[31:26])
         6'b000000: decodeNext = (instr[5:0] == 6'b100000 || instr[5:0] == 6'b100010 || instr[5:0] == 6'b101010) ? EXEC_R :
                                 (instr[5:0] == 6'b001000) ? JR : HALT;
         6'b001000, 6'b001110: decodeNext = EXEC_I;
         6'b100011, 6'b101011: decodeNext = MEM_ADDR;
         6'b000100, 6'b000101: decodeNext = BRANCH;
         6'b000010, 6'b000011: decodeNext = JUMP;
         default:              decodeNext = HALT;
      endcase
   end

   always_comb begin
      nextState    = curState;
      irWe         = 1'b0;
      pcWe         = 1'b0;
      regWe        = 1'b0;
      memReq       = 1'b0;
      memWe        = 1'b0;
      pc_src       = 2'd0;
      mem_addr_sel = 1'b0;
      alu_src_b    = 2'd0;
      reg_dst      = 2'd0;
      wb_sel       = 2'd0;
      case (curState)
         FETCH: begin
            memReq = 1'b1;
            if (mem_ready) begin
               irWe      = 1'b1;
               pcWe      = 1'b1;
               nextState = DECODE;
            end
         end
         DECODE: nextState = decodeNext;
         EXEC_R: nextState = ALU_WB;
         EXEC_I: begin
            alu_src_b = (opReg == 6'b001110) ? 2'd2 : 2'd1;
            nextState = ALU_WB;
         end
         ALU_WB: begin
            reg_dst   = {1'b0, isRType};
            regWe     = !(OVF_SUPPRESS && alu_overflow && ovfOp);
            nextState = FETCH;
         end
         MEM_ADDR: begin
            alu_src_b = 2'd1;
            nextState = (opReg == 6'b101011) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            memReq       = 1'b1;
            mem_addr_sel = 1'b1;
            if (mem_ready) nextState = MEM_WB;
         end
         MEM_WB: begin
            regWe     = 1'b1;
            wb_sel    = 2'd1;
            nextState = FETCH;
         end
         MEM_WR: begin
            memReq       = 1'b1;
            memWe        = 1'b1;
            mem_addr_sel = 1'b1;
            if (mem_ready) nextState = FETCH;
         end
         BRANCH: begin
            pc_src    = 2'd1;
            // opcode bit 0 distinguishes BNE from BEQ
            pcWe      = opReg[0] ? !alu_zero : alu_zero;
            nextState = FETCH;
         end
         JUMP: begin
            pcWe      = 1'b1;
            pc_src    = 2'd2;
            regWe     = opReg[0];
            reg_dst   = opReg[0] ? 2'd2 : 2'd0;
            wb_sel    = opReg[0] ? 2'd2 : 2'd0;
            nextState = FETCH;
         end
         JR: begin
            pcWe      = 1'b1;
            pc_src    = 2'd3;
            nextState = FETCH;
         end
         HALT:    nextState = HALT;
         default: nextState = HALT;
      endcase
   end

   assign ir_we      = irWe & reset_n;
   assign pc_we      = pcWe & reset_n;
   assign reg_we     = regWe & reset_n;
   assign mem_req    = memReq & reset_n;
   assign mem_we     = memWe & reset_n;
   assign alu_opcode = opReg;
   assign alu_funct  = functReg;
   assign state      = curState;
   assign illegal    = illegalReg;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller.
module tb_multicycle_controller;
   logic        clk = 1'b0;
   logic        reset_n, alu_zero, alu_overflow, mem_ready;
   logic [31:0] instr;
   logic        ir_we, pc_we, reg_we, mem_req, mem_we, mem_addr_sel, illegal;
   logic [1:0]  pc_src, alu_src_b, reg_dst, wb_sel;
   logic [5:0]  alu_opcode, alu_funct;
   logic [3:0]  state;
   logic        irWeB, pcWeB, regWeB, memReqB, memWeB, memAddrSelB, illegalB;
   logic [1:0]  pcSrcB, aluSrcBB, regDstB, wbSelB;
   logic [5:0]  aluOpcodeB, aluFunctB;
   logic [3:0]  stateB;
   logic [4:0]  en;
   int          errors = 0;
   int          checks = 0;

   assign en = {ir_we, pc_we, reg_we, mem_req, mem_we};

   always #5 clk = ~clk;

   multicycle_controller #(.OVF_SUPPRESS(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .instr(instr), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .mem_ready(mem_ready), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .mem_req(mem_req),
      .mem_we(mem_we), .pc_src(pc_src), .mem_addr_sel(mem_addr_sel), .alu_src_b(alu_src_b),
      .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_opcode(alu_opcode), .alu_funct(alu_funct),
      .state(state), .illegal(illegal)
   );

   multicycle_controller #(.OVF_SUPPRESS(1'b0)) dutNoSup (
      .clk(clk), .reset_n(reset_n), .instr(instr), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .mem_ready(mem_ready), .ir_we(irWeB), .pc_we(pcWeB), .reg_we(regWeB), .mem_req(memReqB),
      .mem_we(memWeB), .pc_src(pcSrcB), .mem_addr_sel(memAddrSelB), .alu_src_b(aluSrcBB),
      .reg_dst(regDstB), .wb_sel(wbSelB), .alu_opcode(aluOpcodeB), .alu_funct(aluFunctB),
      .state(stateB), .illegal(illegalB)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Zero-wait FETCH then DECODE; leaves the bench in the first post-DECODE state.
   task automatic fetch(input logic [31:0] i, input string nm);
      instr = i;
      mem_ready = 1'b1;
      #1;
      checks++; if (state !== 4'd0 || en !== 5'b11010 || mem_addr_sel !== 1'b0 || pc_src !== 2'd0) begin errors++; $display("FAIL %s_fetch: state=%0d en=%b mas=%b pcsrc=%0d want 0 11010 0 0", nm, state, en, mem_addr_sel, pc_src); end
      tick;
      checks++; if (state !== 4'd1 || en !== 5'b00000) begin errors++; $display("FAIL %s_decode: state=%0d en=%b want 1 00000", nm, state, en); end
      tick;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; instr = 32'h0; alu_zero = 1'b0; alu_overflow = 1'b0; mem_ready = 1'b1;
      tick;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
      checks++; if (alu_opcode !== 6'b000000 || alu_funct !== 6'b100000) begin errors++; $display("FAIL reset_fields: got %b %b want 000000 100000", alu_opcode, alu_funct); end
      checks++; if (en !== 5'b00000) begin errors++; $display("FAIL reset_enables: got %b want 00000", en); end
      reset_n = 1'b1;
   endtask

   task automatic test_add;
      fetch(32'h00851020, "add");
      checks++; if (state !== 4'd2 || en !== 5'b00000 || alu_src_b !== 2'd0) begin errors++; $display("FAIL add_exec: state=%0d en=%b srcb=%0d want 2 00000 0", state, en, alu_src_b); end
      checks++; if (alu_opcode !== 6'b000000 || alu_funct !== 6'b100000) begin errors++; $display("FAIL add_fields: got %b %b want 000000 100000", alu_opcode, alu_funct); end
      tick;
      checks++; if (state !== 4'd3 || en !== 5'b00100 || reg_dst !== 2'd1 || wb_sel !== 2'd0) begin errors++; $display("FAIL add_wb: state=%0d en=%b rd=%0d wb=%0d want 3 00100 1 0", state, en, reg_dst, wb_sel); end
      tick;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL add_done: state=%0d want 0", state); end
   endtask

   task automatic test_fetch_wait;
      mem_ready = 1'b0;
      #1;
      checks++; if (state !== 4'd0 || en !== 5'b00010) begin errors++; $display("FAIL fetchwait_1: state=%0d en=%b want 0 00010", state, en); end
      tick;
      checks++; if (state !== 4'd0 || en !== 5'b00010) begin errors++; $display("FAIL fetchwait_2: state=%0d en=%b want 0 00010", state, en); end
      fetch(32'h0000002A, "slt");
      checks++; if (state !== 4'd2 || alu_funct !== 6'b101010) begin errors++; $display("FAIL slt_exec: state=%0d funct=%b want 2 101010", state, alu_funct); end
      tick;
      alu_overflow = 1'b1;
      #1;
      checks++; if (state !== 4'd3 || reg_we !== 1'b1) begin errors++; $display("FAIL slt_ovf_wb: state=%0d reg_we=%b want 3 1", state, reg_we); end
      alu_overflow = 1'b0;
      tick;
   endtask

   task automatic test_lw;
      fetch(32'h8C000000, "lw");
      checks++; if (state !== 4'd5 || alu_src_b !== 2'd1 || en !== 5'b00000) begin errors++; $display("FAIL lw_addr: state=%0d srcb=%0d en=%b want 5 1 00000", state, alu_src_b, en); end
      tick;
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) mem_ready = 1'b1;
         #1;
         checks++; if (state !== 4'd6 || en !== 5'b00010 || mem_addr_sel !== 1'b1) begin errors++; $display("FAIL lw_rd%0d: state=%0d en=%b mas=%b want 6 00010 1", k, state, en, mem_addr_sel); end
         tick;
      end
      checks++; if (state !== 4'd7 || en !== 5'b00100 || reg_dst !== 2'd0 || wb_sel !== 2'd1) begin errors++; $display("FAIL lw_wb: state=%0d en=%b rd=%0d wb=%0d want 7 00100 0 1", state, en, reg_dst, wb_sel); end
      checks++; if (alu_opcode !== 6'b100011) begin errors++; $display("FAIL lw_opcode: got %b want 100011", alu_opcode); end
      tick;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_done: state=%0d want 0", state); end
   endtask

   task automatic test_sw;
      fetch(32'hAC000000, "sw");
      checks++; if (state !== 4'd5 || alu_src_b !== 2'd1) begin errors++; $display("FAIL sw_addr: state=%0d srcb=%0d want 5 1", state, alu_src_b); end
      tick;
      checks++; if (state !== 4'd8 || en !== 5'b00011 || mem_addr_sel !== 1'b1) begin errors++; $display("FAIL sw_wr: state=%0d en=%b mas=%b want 8 00011 1", state, en, mem_addr_sel); end
      tick;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL sw_done: state=%0d want 0", state); end
   endtask

   task automatic test_branch;
      alu_zero = 1'b1;
      fetch(32'h10000000, "beq");
      checks++; if (state !== 4'd9 || en !== 5'b01000 || pc_src !== 2'd1 || alu_src_b !== 2'd0) begin errors++; $display("FAIL beq_taken: state=%0d en=%b pcsrc=%0d srcb=%0d want 9 01000 1 0", state, en, pc_src, alu_src_b); end
      tick;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL beq_done: state=%0d want 0", state); end
      fetch(32'h14000000, "bne");
      checks++; if (state !== 4'd9 || en !== 5'b00000) begin errors++; $display("FAIL bne_nottaken: state=%0d en=%b want 9 00000", state, en); end
      alu_zero = 1'b0;
      #1;
      checks++; if (en !== 5'b01000 || pc_src !== 2'd1) begin errors++; $display("FAIL bne_taken: en=%b pcsrc=%0d want 01000 1", en, pc_src); end
      tick;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL bne_done: state=%0d want 0", state); end
   endtask

   task automatic test_jump;
      fetch(32'h0C000000, "jal");
      checks++; if (state !== 4'd10 || en !== 5'b01100 || pc_src !== 2'd2 || reg_dst !== 2'd2 || wb_sel !== 2'd2) begin errors++; $display("FAIL jal: state=%0d en=%b pcsrc=%0d rd=%0d wb=%0d want 10 01100 2 2 2", state, en, pc_src, reg_dst, wb_sel); end
      tick;
      fetch(32'h08000000, "j");
      checks++; if (state !== 4'd10 || en !== 5'b01000 || pc_src !== 2'd2) begin errors++; $display("FAIL j: state=%0d en=%b pcsrc=%0d want 10 01000 2", state, en, pc_src); end
      tick;
      fetch(32'h03E00008, "jr");
      checks++; if (state !== 4'd11 || en !== 5'b01000 || pc_src !== 2'd3) begin errors++; $display("FAIL jr: state=%0d en=%b pcsrc=%0d want 11 01000 3", state, en, pc_src); end
      tick;
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL jr_done: state=%0d want 0", state); end
   endtask

   task automatic test_overflow;
      alu_overflow = 1'b1;
      fetch(32'h20000000, "addi");
      checks++; if (state !== 4'd4 || alu_src_b !== 2'd1) begin errors++; $display("FAIL addi_exec: state=%0d srcb=%0d want 4 1", state, alu_src_b); end
      tick;
      checks++; if (state !== 4'd3 || reg_we !== 1'b0 || reg_dst !== 2'd0) begin errors++; $display("FAIL addi_ovf_suppressed: state=%0d reg_we=%b rd=%0d want 3 0 0", state, reg_we, reg_dst); end
      checks++; if (stateB !== 4'd3 || regWeB !== 1'b1) begin errors++; $display("FAIL addi_ovf_nosuppress: state=%0d reg_we=%b want 3 1", stateB, regWeB); end
      tick;
      fetch(32'h38000000, "xori");
      checks++; if (state !== 4'd4 || alu_src_b !== 2'd2) begin errors++; $display("FAIL xori_exec: state=%0d srcb=%0d want 4 2", state, alu_src_b); end
      tick;
      checks++; if (state !== 4'd3 || reg_we !== 1'b1) begin errors++; $display("FAIL xori_ovf_wb: state=%0d reg_we=%b want 3 1", state, reg_we); end
      alu_overflow = 1'b0;
      tick;
   endtask

   task automatic test_reset_abort;
      fetch(32'h8C000000, "abort");
      tick;
      mem_ready = 1'b0;
      #1;
      checks++; if (state !== 4'd6 || mem_req !== 1'b1) begin errors++; $display("FAIL abort_wait: state=%0d mem_req=%b want 6 1", state, mem_req); end
      reset_n = 1'b0;
      #1;
      checks++; if (en !== 5'b00000) begin errors++; $display("FAIL abort_forced: en=%b want 00000", en); end
      tick;
      reset_n = 1'b1;
      #1;
      checks++; if (state !== 4'd0 || en !== 5'b00010) begin errors++; $display("FAIL abort_restart: state=%0d en=%b want 0 00010", state, en); end
   endtask

   task automatic test_halt;
      fetch(32'hFC000000, "halt");
      checks++; if (state !== 4'd12 || illegal !== 1'b1 || en !== 5'b00000) begin errors++; $display("FAIL halt_enter: state=%0d illegal=%b en=%b want 12 1 00000", state, illegal, en); end
      mem_ready = 1'b1;
      tick;
      checks++; if (state !== 4'd12 || illegal !== 1'b1 || en !== 5'b00000) begin errors++; $display("FAIL halt_stay: state=%0d illegal=%b en=%b want 12 1 00000", state, illegal, en); end
      reset_n = 1'b0;
      tick;
      reset_n = 1'b1;
      #1;
      checks++; if (state !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL halt_reset: state=%0d illegal=%b want 0 0", state, illegal); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_fetch_wait;
      test_lw;
      test_sw;
      test_branch;
      test_jump;
      test_overflow;
      test_reset_abort;
      test_halt;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
